// File: rtl/ps2_rx_interface_if.sv
// PS/2 receiver bundle: keyboard pin levels in, received scan-code byte and status out.
interface ps2_rx_interface_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       read_data;
    logic       busy;
    logic       err;

    modport slave  (input ps2_clk, ps2_data, output rx_data, read_data, busy, err);
    modport master (output ps2_clk, ps2_data, input rx_data, read_data, busy, err);
endinterface

// File: rtl/ps2_rx_interface.sv
// Receive-only PS/2 device-to-host port: synchronise and de-glitch the pins,
// deserialise 11-bit frames, check start/parity/stop and strobe out each byte.
module ps2_rx_interface #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_rx_interface_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
    logic          clk_prev_q;
    logic          fall;

    logic [1:0]    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    rx_q, rx_d;
    logic          read_q, read_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [10:0]   frame;
    logic          frame_ok;
    logic          unused_bits;

    // A filtered line only follows its synced input after FILTER_LEN disagreeing samples in a row.
    always_comb begin
        clk_filt_d  = clk_filt_q;
        clk_cnt_d   = '0;
        data_filt_d = data_filt_q;
        data_cnt_d  = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_cnt_q == FILT_LAST) clk_filt_d = clk_sync_q[1];
            else                        clk_cnt_d  = clk_cnt_q + 1'b1;
        end
        if (data_sync_q[1] != data_filt_q) begin
            if (data_cnt_q == FILT_LAST) data_filt_d = data_sync_q[1];
            else                         data_cnt_d  = data_cnt_q + 1'b1;
        end
    end

    assign fall        = clk_prev_q & ~clk_filt_q;
    assign frame       = {data_filt_q, shift_q[10:1]};
    assign frame_ok    = ~frame[0] & (^frame[9:1]) & frame[10];
    assign unused_bits = shift_q[0];

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        to_d     = to_q;
        rx_d     = rx_q;
        read_d   = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (fall && !data_filt_q) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                    shift_d  = frame;
                    to_d     = '0;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d  = frame;
                    bitcnt_d = bitcnt_q + 1'b1;
                    to_d     = '0;
                    // Stop bit: the frame is judged here so strobe, byte and err land together.
                    if (bitcnt_q == 4'd10) begin
                        state_d = DONE;
                        read_d  = 1'b1;
                        err_d   = ~frame_ok;
                        if (frame_ok) rx_d = frame[8:1];
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = IDLE;
                    to_d    = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_cnt_q   <= '0;
            data_cnt_q  <= '0;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            to_q        <= '0;
            rx_q        <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[0], bus.ps2_data};
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
            clk_cnt_q   <= clk_cnt_d;
            data_cnt_q  <= data_cnt_d;
            clk_prev_q  <= clk_filt_q;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            to_q        <= to_d;
            rx_q        <= rx_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_data   = rx_q;
    assign bus.read_data = read_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ps2_rx_interface.sv
// Bench for ps2_rx_interface: open-drain keyboard model with scaled timing and a
// frame-level scoreboard of expected strobes.
module tb_ps2_rx_interface;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 500;
    localparam int HALF           = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_rx  = 8'h00;
    logic       m_err = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    ps2_rx_interface_if bus ();

    ps2_rx_interface #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Lines are pulled up; the keyboard only ever pulls them low.
    assign bus.ps2_clk  = dev_clk_low  ? 1'b0 : 1'b1;
    assign bus.ps2_data = dev_data_low ? 1'b0 : 1'b1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.read_data) obs_q.push_back({bus.err, bus.rx_data});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] frm, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~frm[i];
            wait_cyc(HALF);
            dev_clk_low = 1'b1;
            wait_cyc(HALF);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        logic good;
        par  = (~^d) ^ bad_par;
        send_bits({~bad_stop, par, d, 1'b0}, 11);
        good = !bad_par && !bad_stop;
        if (good) m_rx = d;
        m_err = !good;
        exp_q.push_back({m_err, m_rx});
    endtask

    task automatic check_frames(input string tag);
        logic [8:0] o;
        logic [8:0] e;
        wait_cyc(5);
        check_val({tag, "_strobes"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_val({tag, "_strobe_err_data"}, {23'd0, o}, {23'd0, e});
        end
        obs_q.delete();
        exp_q.delete();
        check_val({tag, "_rx_data"}, {24'd0, bus.rx_data}, {24'd0, m_rx});
        check_val({tag, "_err"}, {31'd0, bus.err}, {31'd0, m_err});
        check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         r;

        wait_cyc(4);
        check_val("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check_val("rst_read", {31'd0, bus.read_data}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        send_frame(8'h1C, 1'b0, 1'b0);
        check_frames("single_1c");

        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_frames("b2b_f0_1c");

        send_frame(8'h1C, 1'b1, 1'b0);
        check_frames("bad_parity");
        wait_cyc(50);
        check_val("err_level_held", {31'd0, bus.err}, {31'd0, m_err});

        dev_clk_low = 1'b1;
        wait_cyc(3);
        dev_clk_low = 1'b0;
        wait_cyc(40);
        check_frames("glitch");

        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
        check_val("timeout_busy_mid", {31'd0, bus.busy}, 32'd1);
        wait_cyc(TIMEOUT_CYCLES + 100);
        m_err = 1'b1;
        check_frames("timeout");

        send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 6);
        reset = 1'b1;
        wait_cyc(3);
        check_val("reset_read_low", {31'd0, bus.read_data}, 32'd0);
        reset = 1'b0;
        m_rx  = 8'h00;
        m_err = 1'b0;
        wait_cyc(HALF);
        check_frames("aborted");
        send_frame(8'h29, 1'b0, 1'b0);
        check_frames("after_reset_29");

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            r = $urandom_range(0, 7);
            send_frame(d, r == 0, r == 1);
            wait_cyc($urandom_range(0, 30));
            if (i % 4 == 3) check_frames("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
